// File: rtl/mem_responder.sv
// Single-ported word RAM shared by the instruction-fetch and data ports.
// Requests are arbitrated, held for WAIT_STATES cycles, then answered with a one-cycle valid pulse.
module mem_responder #(
    parameter int    DEPTH_LOG2  = 12,
    parameter int    WAIT_STATES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [29:0] inst_addr,
    output logic        inst_valid,
    output logic [31:0] inst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_be,
    input  logic [29:0] mem_addr,
    input  logic [31:0] mem_data_in,
    output logic        mem_valid,
    output logic [31:0] mem_data_out,
    output logic        bus_err,
    output logic [1:0]  dbg_state_o
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    logic [31:0] ram [0:(1<<DEPTH_LOG2)-1];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_data_q, last_data_d;
    logic        port_q, port_d;      // 1 = data port granted
    logic [29:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;

    logic        inst_valid_q, mem_valid_q, bus_err_q;
    logic [31:0] inst_q, mem_data_q;

    logic        grant_data;
    logic        do_access;
    logic        acc_port, acc_we;
    logic [29:0] acc_addr;
    logic [3:0]  acc_be;
    logic [31:0] acc_wdata;
    logic        oob;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0] rd_word, merged, resp_word;

    // Data wins contention unless it also won the previous grant.
    assign grant_data = mem_req && !(inst_req && last_data_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_data_d = last_data_q;
        port_d      = port_q;
        addr_d      = addr_q;
        we_d        = we_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        do_access   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (inst_req || mem_req) begin
                    port_d      = grant_data;
                    last_data_d = grant_data;
                    addr_d      = grant_data ? mem_addr : inst_addr;
                    we_d        = grant_data && mem_we;
                    be_d        = mem_be;
                    wdata_d     = mem_data_in;
                    cnt_d       = WS;
                    if (WS == 4'd0) begin
                        state_d   = S_RESP;
                        do_access = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d   = S_RESP;
                    do_access = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the access happens straight out of IDLE, so use the live request.
    always_comb begin
        acc_port  = (state_q == S_IDLE) ? port_d  : port_q;
        acc_addr  = (state_q == S_IDLE) ? addr_d  : addr_q;
        acc_we    = (state_q == S_IDLE) ? we_d    : we_q;
        acc_be    = (state_q == S_IDLE) ? be_d    : be_q;
        acc_wdata = (state_q == S_IDLE) ? wdata_d : wdata_q;
        oob       = |acc_addr[29:DEPTH_LOG2];
        idx       = acc_addr[DEPTH_LOG2-1:0];
        rd_word   = ram[idx];
        merged    = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (acc_be[i]) merged[8*i +: 8] = acc_wdata[8*i +: 8];
        end
        resp_word = oob ? 32'h0000_0000 : (acc_we ? merged : rd_word);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            last_data_q  <= 1'b0;
            port_q       <= 1'b0;
            addr_q       <= 30'd0;
            we_q         <= 1'b0;
            be_q         <= 4'd0;
            wdata_q      <= 32'd0;
            inst_valid_q <= 1'b0;
            mem_valid_q  <= 1'b0;
            inst_q       <= 32'd0;
            mem_data_q   <= 32'd0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_data_q  <= last_data_d;
            port_q       <= port_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            inst_valid_q <= do_access && !acc_port;
            mem_valid_q  <= do_access && acc_port;
            if (do_access) begin
                if (acc_port) mem_data_q <= resp_word;
                else          inst_q     <= resp_word;
                if (oob)      bus_err_q  <= 1'b1;
            end
        end
    end

    // Reset on the commit edge discards the store.
    always_ff @(posedge clk) begin
        if (!rst && do_access && acc_we && !oob) ram[idx] <= merged;
    end

    assign inst_valid   = inst_valid_q;
    assign inst         = inst_q;
    assign mem_valid    = mem_valid_q;
    assign mem_data_out = mem_data_q;
    assign bus_err      = bus_err_q;
    assign dbg_state_o  = state_q;

endmodule
